// File: rtl/forward_scoreboard.sv
// Register scoreboard and forwarding selector: pending-result counters raise a combinational decode stall, and each operand gets a forward source.
// A count holds the decode-visible busy cycles that remain; the issue cycle counts as the first cycle of the latency.
module forward_scoreboard #(
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter int NSTAGE = 3,
  parameter int MAXLAT = 3,
  parameter int LW     = $clog2(MAXLAT + 1),
  parameter int SW     = $clog2(NSTAGE + 1)
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 issue_valid,
  input  logic                 issue_wr,
  input  logic [AW-1:0]        issue_rd,
  input  logic [LW-1:0]        issue_lat,
  input  logic [AW-1:0]        id_rs,
  input  logic [AW-1:0]        id_rt,
  input  logic [NSTAGE-1:0]    stage_wr,
  input  logic [NSTAGE*AW-1:0] stage_rd,
  input  logic                 flush,
  input  logic                 stat_clr,
  output logic                 stall,
  output logic [SW-1:0]        fwd_rs,
  output logic [SW-1:0]        fwd_rt,
  output logic [AW:0]          pend_cnt,
  output logic [31:0]          stall_cycles
);

  logic [LW-1:0] cnt_q [NREG];
  logic [LW-1:0] cnt_d [NREG];
  logic [AW:0]   pend_q, pend_d;
  logic [31:0]   stall_cycles_q, stall_cycles_d;
  logic [31:0]   lat_ext;
  logic [LW-1:0] lat_sat;
  logic          issue_acc;

  always_comb begin
    stall = 1'b0;
    if ((id_rs != '0) && (cnt_q[id_rs] != '0)) stall = 1'b1;
    if ((id_rt != '0) && (cnt_q[id_rt] != '0)) stall = 1'b1;
  end

  always_comb begin
    lat_ext = 32'(issue_lat);
    lat_sat = issue_lat;
    if (lat_ext > 32'(MAXLAT)) lat_sat = LW'(MAXLAT);
  end

  assign issue_acc = issue_valid & issue_wr & ~stall & (issue_rd != '0) & (lat_sat != '0);

  always_comb begin
    pend_d = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = '0;
      if (r == 0 || flush) begin
        cnt_d[r] = '0;
      end else if (issue_acc && (issue_rd == AW'(r))) begin
        // A younger writer always overwrites an older pending count (WAW).
        cnt_d[r] = lat_sat - LW'(1);
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - LW'(1);
      end
      pend_d = pend_d + (AW+1)'(cnt_d[r] != '0);
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stat_clr) begin
      stall_cycles_d = '0;
    end else if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  // Walk from the oldest stage down so the youngest matching stage wins.
  always_comb begin
    fwd_rs = '0;
    fwd_rt = '0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (stage_wr[k] && (stage_rd[k*AW +: AW] == id_rs)) fwd_rs = SW'(k + 1);
      if (stage_wr[k] && (stage_rd[k*AW +: AW] == id_rt)) fwd_rt = SW'(k + 1);
    end
    if (id_rs == '0) fwd_rs = '0;
    if (id_rt == '0) fwd_rt = '0;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt_q          <= '{default: '0};
      pend_q         <= '0;
      stall_cycles_q <= '0;
    end else begin
      cnt_q          <= cnt_d;
      pend_q         <= pend_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign pend_cnt     = pend_q;
  assign stall_cycles = stall_cycles_q;

endmodule
